// File: rtl/store_align_buffer_pkg.sv
// Shared store-mode codes, default queue depth and misalignment masks for the
// store alignment buffer.
package store_align_buffer_pkg;

  typedef enum logic [2:0] {
    SL_WORD      = 3'd0,
    SL_HALF      = 3'd1,
    SL_BYTE      = 3'd2,
    SL_WORDLEFT  = 3'd3,
    SL_WORDRIGHT = 3'd4
  } sl_mode_e;

  localparam int SB_DEPTH = 4;

  // Low address bits that must be zero for an aligned word / half store.
  localparam logic [1:0] SB_ERR_WORD_MASK = 2'b11;
  localparam logic [1:0] SB_ERR_HALF_MASK = 2'b01;

endpackage

// File: rtl/store_lane_align.sv
// Combinational mapping of store mode and bus offset onto bus byte lanes:
// aligned data, byte enables and a misalignment / illegal-mode flag.
module store_lane_align
  import store_align_buffer_pkg::*;
#(
  parameter  int BUS_BYTES = 4,
  localparam int OFF_W     = $clog2(BUS_BYTES),
  localparam int BUS_W     = BUS_BYTES * 8
) (
  input  logic [OFF_W-1:0]     off_i,
  input  logic [31:0]          data_i,
  input  logic [2:0]           mode_i,
  output logic [BUS_W-1:0]     data_o,
  output logic [BUS_BYTES-1:0] be_o,
  output logic                 err_o
);

  logic [1:0]       w;
  logic [OFF_W-1:0] wbase;
  logic [OFF_W-1:0] pos;
  logic [31:0]      wdata;
  logic [3:0]       wbe;

  assign w     = off_i[1:0];
  assign wbase = off_i & ~OFF_W'(3);

  // Build the store inside a 32-bit word, then slide it to its lane position.
  always_comb begin
    wdata = '0;
    wbe   = '0;
    err_o = 1'b0;
    pos   = wbase;
    case (mode_i)
      SL_WORD: begin
        wdata = data_i;
        wbe   = 4'hF;
        err_o = |(w & SB_ERR_WORD_MASK);
      end
      SL_HALF: begin
        wdata = {16'b0, data_i[15:0]};
        wbe   = 4'b0011;
        pos   = off_i;
        err_o = |(w & SB_ERR_HALF_MASK);
      end
      SL_BYTE: begin
        wdata = {24'b0, data_i[7:0]};
        wbe   = 4'b0001;
        pos   = off_i;
      end
      SL_WORDLEFT: begin
        wdata = data_i >> {2'd3 - w, 3'b000};
        wbe   = 4'hF >> (2'd3 - w);
      end
      SL_WORDRIGHT: begin
        wdata = data_i << {w, 3'b000};
        wbe   = 4'hF << w;
      end
      default: err_o = 1'b1;
    endcase
  end

  assign data_o = BUS_W'(wdata) << {pos, 3'b000};
  assign be_o   = BUS_BYTES'(wbe) << pos;

endmodule

// File: rtl/store_align_buffer.sv
// Store queue between MEM and the data bus: aligns stores, merges same-word
// back-to-back stores into the tail, drains over valid/ready, probes loads.
module store_align_buffer
  import store_align_buffer_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int DEPTH     = SB_DEPTH,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [31:0]            req_data,
  input  logic [2:0]             req_mode,
  output logic                   err_valid,
  output logic [ADDR_W-1:0]      err_addr,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BUS_BYTES*8-1:0] mem_data,
  output logic [BUS_BYTES-1:0]   mem_be,
  input  logic [ADDR_W-1:0]      chk_addr,
  output logic                   chk_hit,
  output logic                   sb_empty
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BUS_W = BUS_BYTES * 8;

  logic [ADDR_W-1:0]    addr_q [DEPTH];
  logic [BUS_W-1:0]     data_q [DEPTH];
  logic [BUS_BYTES-1:0] be_q   [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PTR_W-1:0]     head_q, tail_q, tail_last;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_valid_q;
  logic [ADDR_W-1:0]    err_addr_q;

  logic [ADDR_W-1:0]    req_baddr, chk_baddr;
  logic [BUS_W-1:0]     lane_data, merged_data;
  logic [BUS_BYTES-1:0] lane_be;
  logic                 lane_err;
  logic                 tail_match, can_merge, pop;
  logic                 accept, do_err, do_merge, do_push;

  store_lane_align #(.BUS_BYTES(BUS_BYTES)) u_align (
    .off_i  (req_addr[OFF_W-1:0]),
    .data_i (req_data),
    .mode_i (req_mode),
    .data_o (lane_data),
    .be_o   (lane_be),
    .err_o  (lane_err)
  );

  assign req_baddr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign chk_baddr = {chk_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign tail_last = tail_q - PTR_W'(1);

  assign mem_valid  = (count_q != '0);
  assign sb_empty   = (count_q == '0);
  assign pop        = mem_valid & mem_ready;
  assign tail_match = mem_valid && (addr_q[tail_last] == req_baddr);
  assign can_merge  = tail_match && !((count_q == CNT_W'(1)) && pop);

  // The pop exclusion only bites at count==1, where count<DEPTH already holds,
  // so tail_match stands in for can_merge and keeps mem_ready off this path.
  assign req_ready = (count_q < CNT_W'(DEPTH)) | tail_match;

  assign accept   = req_valid & req_ready;
  assign do_err   = accept & lane_err;
  assign do_merge = accept & ~lane_err & can_merge;
  assign do_push  = accept & ~lane_err & ~can_merge;

  assign mem_addr  = mem_valid ? addr_q[head_q] : '0;
  assign mem_data  = mem_valid ? data_q[head_q] : '0;
  assign mem_be    = mem_valid ? be_q[head_q]   : '0;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

  always_comb begin
    merged_data = data_q[tail_last];
    for (int b = 0; b < BUS_BYTES; b++)
      if (lane_be[b]) merged_data[b*8 +: 8] = lane_data[b*8 +: 8];
  end

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && (addr_q[i] == chk_baddr)) chk_hit = 1'b1;
  end

  always_comb begin
    vld_d = vld_q;
    if (pop)     vld_d[head_q] = 1'b0;
    if (do_push) vld_d[tail_q] = 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      vld_q       <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      head_q      <= head_q + PTR_W'(pop);
      tail_q      <= tail_q + PTR_W'(do_push);
      count_q     <= count_d;
      vld_q       <= vld_d;
      err_valid_q <= do_err;
      if (do_err) err_addr_q <= req_addr;
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= req_baddr;
      data_q[tail_q] <= lane_data;
      be_q[tail_q]   <= lane_be;
    end else if (do_merge) begin
      data_q[tail_last] <= merged_data;
      be_q[tail_last]   <= be_q[tail_last] | lane_be;
    end
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Next-generation store path between the MEM stage and the data bus.
- Aligns sw/sh/sb/swl/swr data onto a parametrised-width bus and generates byte enables.
- Queues aligned stores in a small FIFO; merges back-to-back stores to the same bus word; drains to memory over a valid/ready handshake.
- Provides an address-match probe so the load path can stall on a pending store, and an empty flag for sync/eret drain.

Parameters:
- BUS_BYTES, 4: bus width in bytes; legal values 4 or 8. Bus data width is BUS_BYTES*8.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  unaligned register data (rt).
- req_mode  in  3  store mode: slword/slhalf/slbyte/slwordleft/slwordright.
- err_valid  out  1  one-cycle pulse: the previously accepted request was misaligned or had an illegal mode.
- err_addr  out  ADDR_W  address of the faulting request.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  memory accepts the head.
- mem_addr  out  ADDR_W  bus-aligned address (low log2(BUS_BYTES) bits zero).
- mem_data  out  BUS_BYTES*8  aligned data.
- mem_be  out  BUS_BYTES  byte enables.
- chk_addr  in  ADDR_W  load address to probe.
- chk_hit  out  1  combinational: some valid entry has the same bus-aligned address as chk_addr.
- sb_empty  out  1  no valid entries.

Behaviour:
- Reset (reset=0, asynchronous): count=0; head and tail pointers 0; all entry valid bits 0; err_valid=0; err_addr=0; mem_valid=0; sb_empty=1. mem_addr, mem_data and mem_be read as 0 while empty.
- Alignment (combinational, per request):
  - off = req_addr[log2(BUS_BYTES)-1:0]; w = off[1:0]; wbase = off with bits[1:0] cleared.
  - word: data placed at byte wbase; BE = 4'b1111 << wbase.
  - half: data[15:0] placed at byte off; BE = 2'b11 << off.
  - byte: data[7:0] placed at byte off; BE = 1 << off.
  - wordleft: data >> ((3-w)*8) placed at wbase; BE = (4'b1111 >> (3-w)) << wbase.
  - wordright: data << (w*8) placed at wbase; BE = (4'b1111 << w) << wbase, truncated to 4 bits.
  - Bytes outside BE are 0.
- Errors:
  - word with w!=0, or half with off[0]=1, or undefined mode: request is consumed (req_ready behaves normally) but not enqueued.
  - err_valid=1 on the next cycle, with err_addr = req_addr of that request. err_valid otherwise 0.
- Merge:
  - can_merge = count>0, tail entry address equals the new bus address, and NOT (count==1 & mem_valid & mem_ready).
  - On merge, the tail entry takes new bytes where the new BE is set and keeps old bytes elsewhere; tail BE |= new BE. count is unchanged.
- Enqueue: when not merging and no error, write the tail entry and advance the tail pointer (wraps modulo DEPTH).
- req_ready = (count < DEPTH) | can_merge. There is no combinational path from mem_ready to req_ready; push-while-full-and-popping is refused.
- Dequeue: mem_valid = count>0. When mem_valid & mem_ready, advance the head pointer (wraps). Head outputs are held stable while mem_valid & !mem_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- chk_hit compares all valid entries, including an entry popping this cycle.
- Latency: an accepted store is visible on mem_* the next cycle at the earliest.

Decomposition:
- define.v holds:
  - the existing sl* mode codes;
  - a new `sbdepth default;
  - a new `sberr mask.
- Sub-module store_lane_align is natural: the purely combinational mode/offset to data/BE mapping, parametrised by BUS_BYTES.
- The FIFO, merge and probe logic stay in store_align_buffer.

Test Plan:
- BUS_BYTES=4, reset low then high. Accept slword addr 0x100, data 0x11223344 -> next cycle mem_valid=1, mem_addr=0x100, mem_data=0x11223344, mem_be=1111. mem_ready=1 -> sb_empty=1.
- mem_ready=0. Issue slbyte 0x203 data 0xAA, then slhalf 0x200 data 0xBEEF -> single entry: mem_data=0xAA00BEEF, mem_be=1011, count=1.
- swl addr 0x301 data 0x12345678 -> be=0011, data=0x00001234. swr addr 0x302 data 0x12345678 -> be=1100, data=0x56780000.
- slword addr 0x102 -> no enqueue; err_valid=1 one cycle later, err_addr=0x102; sb_empty stays 1.
- mem_ready=0. Fill DEPTH=4 distinct words -> req_ready=0. A 5th store to the tail's word is still accepted and merged. Release mem_ready -> 4 pops in order, pointers wrap correctly.
- BUS_BYTES=8: slhalf addr 0x106 data 0xCAFE -> mem_addr=0x100, mem_be=0xC0, mem_data[63:48]=0xCAFE. With chk_addr=0x104, chk_hit=1; reset asserted mid-drain -> chk_hit=0, mem_valid=0 immediately.
